// File: rtl/pc_next_stage_pkg.sv
// Shared definitions for the PC stage: state encoding and default parameters.
package pc_pkg;

    // RUN: no buffered branch; PEND: one branch held in pend_q while stalled
    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pc_state_e;

    localparam int unsigned DEFAULT_WIDTH    = 32;
    localparam int unsigned DEFAULT_STEP     = 4;
    localparam int unsigned DEFAULT_RESET_PC = 0;
    localparam int unsigned DEFAULT_CNT_W    = 8;

endpackage

// File: rtl/pc_next_stage_if.sv
// Bus between the PC stage and its control/consumer logic.
// master: the side issuing stall/branch requests and observing the PC.
// slave:  the PC stage itself.
interface pc_next_stage_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
);
    logic             stall;
    logic             branch_valid;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] tgt_sel;
    logic             take;
    logic             pending;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output stall, branch_valid, branch_target,
        input  pc, pc_plus, tgt_sel, take, pending, redirect_cnt
    );

    modport slave (
        input  stall, branch_valid, branch_target,
        output pc, pc_plus, tgt_sel, take, pending, redirect_cnt
    );
endinterface

// File: rtl/pc_next_stage_mux2.sv
// WIDTH-wide 2:1 select: y = s ? x2 : x1.
module pc_mux2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             s,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] y
);
    assign y = s ? x2 : x1;
endmodule

// File: rtl/pc_next_stage.sv
// Program-counter stage: holds PC, forms PC+STEP and the branch target,
// drives the select, and buffers one branch that arrives during a stall.
import pc_pkg::*;

module pc_next_stage #(
    parameter int unsigned     WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter logic [WIDTH-1:0] STEP     = WIDTH'(DEFAULT_STEP),
    parameter int unsigned     CNT_W    = DEFAULT_CNT_W
) (
    input logic            clk,
    input logic            rst,
    pc_next_stage_if.slave bus
);
    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             take;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] tgt_sel;
    logic [WIDTH-1:0] mux_y;

    // Sequential candidate; wraps modulo 2^WIDTH with no carry out
    assign pc_plus = pc_q + STEP;

    pc_mux2 #(.WIDTH(WIDTH)) u_mux (
        .s  (take),
        .x1 (pc_plus),
        .x2 (tgt_sel),
        .y  (mux_y)
    );

    // Next-state, select and counter logic
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        take    = 1'b0;
        // A live branch always beats the buffered one
        tgt_sel = (state_q == PEND && !bus.branch_valid) ? pend_q : bus.branch_target;

        unique case (state_q)
            RUN: begin
                if (!bus.stall) begin
                    take = bus.branch_valid;
                end else if (bus.branch_valid) begin
                    pend_d  = bus.branch_target;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (bus.stall) begin
                    if (bus.branch_valid) begin
                        pend_d = bus.branch_target;
                    end
                end else begin
                    take    = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        pc_d      = bus.stall ? pc_q : mux_y;
        pending_d = (state_d == PEND);
        cnt_d     = (take && !bus.stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // State, PC, buffered branch and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            pend_q    <= '0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus      = pc_plus;
    assign bus.tgt_sel      = tgt_sel;
    assign bus.take         = take;
    assign bus.pending      = pending_q;
    assign bus.redirect_cnt = cnt_q;
endmodule

// File: tb/tb_pc_next_stage.sv
// Directed bench for pc_next_stage with an expected-result queue and a
// small reference model of the PC/pending/counter behaviour.
module tb_pc_next_stage;
    localparam int unsigned W = 32;
    localparam int unsigned C = 8;

    typedef struct {
        logic [W-1:0] pc;
        logic         pending;
        logic [C-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    // reference model state
    logic [W-1:0] m_pc;
    logic         m_pend;
    logic [W-1:0] m_pendq;
    logic [C-1:0] m_cnt;

    pc_next_stage_if #(.WIDTH(W), .CNT_W(C)) bus ();

    pc_next_stage #(
        .WIDTH    (W),
        .RESET_PC (32'h0),
        .STEP     (32'h4),
        .CNT_W    (C)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("pc", bus.pc, e.pc);
            chk("pending", W'(bus.pending), W'(e.pending));
            chk("cnt", W'(bus.redirect_cnt), W'(e.cnt));
        end
    endtask

    task automatic rst_step(input logic st, input logic bv, input logic [W-1:0] tgt);
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        bus.stall = st;
        bus.branch_valid = bv;
        bus.branch_target = tgt;
        m_pc = '0; m_pend = 1'b0; m_pendq = '0; m_cnt = '0;
        e.pc = m_pc; e.pending = m_pend; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic step(input logic st, input logic bv, input logic [W-1:0] tgt);
        exp_t         e;
        logic         e_take;
        logic [W-1:0] e_tgt;
        @(negedge clk);
        rst = 1'b0;
        bus.stall = st;
        bus.branch_valid = bv;
        bus.branch_target = tgt;
        #1;
        e_take = m_pend ? !st : (!st && bv);
        e_tgt  = (m_pend && !bv) ? m_pendq : tgt;
        chk("take", W'(bus.take), W'(e_take));
        chk("tgt_sel", bus.tgt_sel, e_tgt);
        chk("pc_plus", bus.pc_plus, m_pc + 32'd4);
        if (!st) begin
            m_pc   = e_take ? e_tgt : m_pc + 32'd4;
            m_pend = 1'b0;
            if (e_take && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end else if (bv) begin
            m_pendq = tgt;
            m_pend  = 1'b1;
        end
        e.pc = m_pc; e.pending = m_pend; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.stall = 1'b1;
        bus.branch_valid = 1'b1;
        bus.branch_target = 32'hDEAD_BEEF;
        m_pc = '0; m_pend = 1'b0; m_pendq = '0; m_cnt = '0;

        // 1: reset dominates stall and branch_valid
        rst_step(1'b1, 1'b1, 32'hDEAD_BEEF);
        rst_step(1'b1, 1'b1, 32'hDEAD_BEEF);
        chk("t1_pc", bus.pc, 32'h0);
        chk("t1_pending", W'(bus.pending), 32'h0);
        chk("t1_cnt", W'(bus.redirect_cnt), 32'h0);

        // 2: sequential run, target ignored while branch_valid is low
        step(1'b0, 1'b0, 32'h1234_5678);
        chk("t2_pc4", bus.pc, 32'h4);
        step(1'b0, 1'b0, $urandom);
        step(1'b0, 1'b0, $urandom);
        chk("t2_pc12", bus.pc, 32'hC);
        chk("t2_cnt", W'(bus.redirect_cnt), 32'h0);

        // 3: unstalled branch, one-cycle latency
        step(1'b0, 1'b1, 32'h100);
        chk("t3_pc", bus.pc, 32'h100);
        step(1'b0, 1'b0, 32'h0);
        chk("t3_pc_next", bus.pc, 32'h104);
        chk("t3_cnt", W'(bus.redirect_cnt), 32'h1);

        // 4: branches during stall, latest wins on release
        step(1'b1, 1'b1, 32'h200);
        chk("t4_hold", bus.pc, 32'h104);
        chk("t4_pending", W'(bus.pending), 32'h1);
        step(1'b1, 1'b1, 32'h300);
        step(1'b1, 1'b0, 32'h0);
        chk("t4_hold2", bus.pc, 32'h104);
        step(1'b0, 1'b0, 32'hABC);
        chk("t4_pc", bus.pc, 32'h300);
        chk("t4_pending_clr", W'(bus.pending), 32'h0);

        // 5: live branch in the release cycle beats the buffered one
        step(1'b1, 1'b1, 32'h400);
        step(1'b0, 1'b1, 32'h500);
        chk("t5_pc", bus.pc, 32'h500);
        chk("t5_pending", W'(bus.pending), 32'h0);

        // 6: wrap-around and counter saturation
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("t6_wrap", bus.pc, 32'h0);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
        end
        chk("t6_sat", W'(bus.redirect_cnt), 32'hFF);

        // extra: reset while a branch is buffered
        step(1'b1, 1'b1, 32'h600);
        chk("tx_pending", W'(bus.pending), 32'h1);
        rst_step(1'b0, 1'b0, 32'h0);
        chk("tx_pc", bus.pc, 32'h0);
        chk("tx_pending_clr", W'(bus.pending), 32'h0);
        step(1'b0, 1'b0, 32'h777);
        chk("tx_pc_after", bus.pc, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
